// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch definitions: widths, the halt encoding, the opcode
// fields fetch and decode care about, and the queued fetch entry type.
package legv8_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;

  // BR XZR: software ends the program with this word
  localparam logic [INSTR_W-1:0] HALT_WORD = 32'hD60003E0;

  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [10:0] OP_BR    = 11'b11010110000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch -> decode handshake. The fetch side is the master and presents the
// head-of-queue word; decode is the slave and answers with ready.
interface instr_fetch_if #(
  parameter int ADDR_W = 16
);
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (output instr, output instr_pc, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_pc, input instr_valid, output instr_ready);
endinterface

// File: rtl/instr_fetch_queue.sv
// fetch_queue: 2-entry FIFO of fetch entries. Entry 0 is always the head, so
// the output needs no read mux. Flush empties it in one cycle; the caller
// never pops when empty and never pushes when full without a pop.
module fetch_queue
  import legv8_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t ent [2];

  assign head = ent[0];

  // Storage and occupancy; a pop shifts entry 1 down into the head slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= 2'd0;
      ent[0] <= '0;
      ent[1] <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) ent[0] <= din;
          else               ent[1] <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent[0] <= ent[1];
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            ent[0] <= din;
          end else begin
            ent[0] <= ent[1];
            ent[1] <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, reads the combinational instruction ROM and
// queues {word, pc} for decode. Redirects flush and refetch; the halt word
// freezes fetch until the next redirect or reset.
// Optional macro FETCH_BRANCH_PREDECODE_EN: follow unconditional B at fetch
// instead of waiting for execute to redirect.
module instr_fetch
  import legv8_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       HALT_WORD = 32'hD60003E0
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [31:0]       rom_data,
  instr_fetch_if.master     dec,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [1:0]        count;
  fetch_entry_t      head;
  fetch_entry_t      din;
  logic              deq;
  logic              can_enq;
  logic              fetch;
  logic              is_halt;

  assign rom_address     = pc;
  assign dec.instr_valid = (count != 2'd0);
  assign dec.instr       = head.instr;
  assign dec.instr_pc    = head.pc;

  assign deq     = dec.instr_valid && dec.instr_ready;
  // a full queue still takes a word when decode frees a slot this cycle
  assign can_enq = (count != 2'd2) || deq;
  assign fetch   = !redirect_valid && !halted && can_enq;
  assign is_halt = (rom_data == HALT_WORD);

  assign din.instr = rom_data;
  assign din.pc    = pc;

`ifdef FETCH_BRANCH_PREDECODE_EN
  logic [31:0] b_off;
  logic        is_b;
  assign b_off = {{6{rom_data[25]}}, rom_data[25:0]};
  assign is_b  = (rom_data[31:26] == OP_B);
`endif

  // Next PC: redirect wins, then the sequential (or predecoded) fetch step.
  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (fetch) begin
      pc_next = pc + ADDR_W'(1);
`ifdef FETCH_BRANCH_PREDECODE_EN
      if (!is_halt && is_b) pc_next = pc + b_off[ADDR_W-1:0];
`endif
    end
  end

  // PC and halt flag; a redirect always revives a halted fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else begin
      pc <= pc_next;
      if (redirect_valid)        halted <= 1'b0;
      else if (fetch && is_halt) halted <= 1'b1;
    end
  end

  fetch_queue u_queue (
    .clock (clock),
    .reset (reset),
    .push  (fetch),
    .pop   (deq),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .count (count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed phases push the words decode must receive
// into a scoreboard queue; an independent monitor pops and compares on every
// completed handshake. Direct checks cover PC, halt and valid timing.
module tb_instr_fetch;

  logic        clock;
  logic        reset;
  logic [15:0] rom_address;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halted;

  instr_fetch_if #(.ADDR_W(16)) dec ();

  instr_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .rom_address    (rom_address),
    .rom_data       (rom_data),
    .dec            (dec),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  localparam logic [31:0] HALT = 32'hD60003E0;

  function automatic logic [31:0] rom_f(input logic [15:0] a);
    case (a)
      16'h0000: rom_f = 32'h91002841;
      16'h0001: rom_f = 32'hF8001061;
      16'h0004: rom_f = 32'h910003E7;
      16'h000A: rom_f = 32'h17FFFFFA;
      16'h000B: rom_f = HALT;
      16'h0021: rom_f = HALT;
      default:  rom_f = 32'h8B000000 | {16'h0000, a};
    endcase
  endfunction

  assign rom_data = rom_f(rom_address);

  typedef struct {
    logic [31:0] instr;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] a);
    exp_t e;
    e.instr = rom_f(a);
    e.pc    = a;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    exp_q.delete();
  endtask

  // Scoreboard monitor: every accepted word must be the next expected one.
  always @(negedge clock) begin
    if (!reset && dec.instr_valid && dec.instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deq_unexpected: got pc %h instr %h expected nothing", dec.instr_pc, dec.instr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("deq_pc", {16'h0000, dec.instr_pc}, {16'h0000, mon_e.pc});
        chk("deq_instr", dec.instr, mon_e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    dec.instr_ready = 1'b0;

    // Phase 1: reset state, then streaming with ready held high
    dec.instr_ready = 1'b1;
    do_reset();
    chk("rst_valid", {31'b0, dec.instr_valid}, 32'd0);
    chk("rst_instr", dec.instr, 32'd0);
    chk("rst_pc", {16'h0, dec.instr_pc}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_addr", {16'h0, rom_address}, 32'd0);
    push_exp(16'h0000);
    push_exp(16'h0001);
    reset = 1'b0;
    tick();
    chk("p1_instr0", dec.instr, 32'h91002841);
    chk("p1_pc0", {16'h0, dec.instr_pc}, 32'd0);
    chk("p1_addr1", {16'h0, rom_address}, 32'd1);
    tick();
    chk("p1_instr1", dec.instr, 32'hF8001061);
    chk("p1_pc1", {16'h0, dec.instr_pc}, 32'd1);
    tick();
    chk("p1_addr3", {16'h0, rom_address}, 32'd3);
    dec.instr_ready = 1'b0;
    chk("p1_drained", exp_q.size(), 32'd0);

    // Phase 2: backpressure from reset, then release
    do_reset();
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("p2_addr_hold", {16'h0, rom_address}, 32'd2);
    chk("p2_valid", {31'b0, dec.instr_valid}, 32'd1);
    chk("p2_head", {16'h0, dec.instr_pc}, 32'd0);
    tick();
    chk("p2_addr_hold2", {16'h0, rom_address}, 32'd2);
    chk("p2_head2", {16'h0, dec.instr_pc}, 32'd0);
    for (int i = 0; i < 4; i++) push_exp(16'(i));
    dec.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    dec.instr_ready = 1'b0;
    chk("p2_drained", exp_q.size(), 32'd0);

    // Phase 3: redirect with a full queue and a simultaneous dequeue
    tick();
    chk("p3_full_head", {16'h0, dec.instr_pc}, 32'd4);
    push_exp(16'h0004);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0004;
    dec.instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    dec.instr_ready = 1'b0;
    chk("p3_flush_valid", {31'b0, dec.instr_valid}, 32'd0);
    chk("p3_addr", {16'h0, rom_address}, 32'd4);
    tick();
    chk("p3_instr", dec.instr, 32'h910003E7);
    chk("p3_pc", {16'h0, dec.instr_pc}, 32'd4);
    chk("p3_drained", exp_q.size(), 32'd0);

`ifndef FETCH_BRANCH_PREDECODE_EN
    // Phase 4: run into the halt word, drain, then revive with a redirect
    dec.instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 12; i++) push_exp(16'(i));
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("p4_halted", {31'b0, halted}, 32'd1);
    chk("p4_addr_frz", {16'h0, rom_address}, 32'h0C);
    chk("p4_halt_pc", {16'h0, dec.instr_pc}, 32'h0B);
    chk("p4_halt_instr", dec.instr, HALT);
    tick();
    chk("p4_empty", {31'b0, dec.instr_valid}, 32'd0);
    tick();
    tick();
    chk("p4_empty2", {31'b0, dec.instr_valid}, 32'd0);
    chk("p4_addr_frz2", {16'h0, rom_address}, 32'h0C);
    chk("p4_drained", exp_q.size(), 32'd0);
    push_exp(16'h0000);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0000;
    tick();
    redirect_valid = 1'b0;
    chk("p4_unhalt", {31'b0, halted}, 32'd0);
    chk("p4_rd_valid", {31'b0, dec.instr_valid}, 32'd0);
    chk("p4_rd_addr", {16'h0, rom_address}, 32'd0);
    tick();
    chk("p4_resume", dec.instr, 32'h91002841);
    chk("p4_resume_addr", {16'h0, rom_address}, 32'd1);
    tick();
    dec.instr_ready = 1'b0;
    chk("p4_resume_pc1", {16'h0, dec.instr_pc}, 32'd1);
    chk("p4_drained2", exp_q.size(), 32'd0);
`else
    // Phase 5: B -6 at address 10 is followed at fetch time
    dec.instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 11; i++) push_exp(16'(i));
    reset = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    chk("p5_b_target", {16'h0, rom_address}, 32'd4);
    chk("p5_b_pc", {16'h0, dec.instr_pc}, 32'h0A);
    chk("p5_b_instr", dec.instr, 32'h17FFFFFA);
    tick();
    dec.instr_ready = 1'b0;
    chk("p5_after_b", {16'h0, dec.instr_pc}, 32'd4);
    chk("p5_addr5", {16'h0, rom_address}, 32'd5);
    chk("p5_drained", exp_q.size(), 32'd0);
`endif

    // Phase 6: reset with a full queue while halted
    dec.instr_ready = 1'b0;
    do_reset();
    reset = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0020;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    chk("p6_halted", {31'b0, halted}, 32'd1);
    chk("p6_valid", {31'b0, dec.instr_valid}, 32'd1);
    chk("p6_addr", {16'h0, rom_address}, 32'h22);
    chk("p6_head", {16'h0, dec.instr_pc}, 32'h20);
    tick();
    reset = 1'b1;
    tick();
    chk("p6_rst_valid", {31'b0, dec.instr_valid}, 32'd0);
    chk("p6_rst_halted", {31'b0, halted}, 32'd0);
    chk("p6_rst_addr", {16'h0, rom_address}, 32'd0);
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Reader side of the instruction ROM: owns the PC, drives the word address into the combinational ROM and captures the returned 32-bit LEGv8 word.
- Buffers fetched words in a 2-entry queue and hands them to decode over a valid/ready handshake.
- Accepts redirects from execute (taken branches, BR) and stops fetching at the halt word.

Parameters:
- ADDR_W, 16, ROM word-address width (one address per 32-bit instruction).
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_WORD, 32'hD60003E0, encoding (BR XZR) that stops fetch.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rom_address  out  ADDR_W  word address to ROM, equal to the PC register.
- rom_data  in  32  ROM word for rom_address, valid in the same cycle (combinational ROM).
- instr  out  32  head-of-queue instruction.
- instr_pc  out  ADDR_W  word address of instr.
- instr_valid  out  1  queue non-empty.
- instr_ready  in  1  decode accepts instr this cycle.
- redirect_valid  in  1  flush and refetch from redirect_pc.
- redirect_pc  in  ADDR_W  redirect target word address.
- halted  out  1  halt word fetched; fetch frozen.

Behaviour:
- Reset state: pc=RESET_PC, queue empty, instr_valid=0, instr=0, instr_pc=0, halted=0.
- Priority, highest first: reset > redirect > halted > normal fetch.
- Dequeue occurs when instr_valid && instr_ready.
- Enqueue is allowed when count<2, or when count==2 and a dequeue happens in the same cycle.
- Normal fetch: if enqueue is allowed and halted=0, capture {rom_data, pc} at the tail and set pc <= pc+1, mod 2^ADDR_W (16'hFFFF wraps to 16'h0000). Otherwise pc holds.
- Latency: a word fetched at edge N is visible on instr at N+1. Back-to-back throughput is 1 instruction per cycle.
- Queue order is strictly FIFO; no word is dropped or duplicated under backpressure.
- Halt: when a captured word equals HALT_WORD:
  - it is enqueued normally;
  - pc advances to halt address+1 and then freezes;
  - halted=1 from the next cycle;
  - no further enqueues. Queued entries, including the halt word, still drain.
- Redirect, when redirect_valid=1:
  - queue is flushed (count=0) and pc <= redirect_pc;
  - halted <= 0;
  - no enqueue that cycle;
  - instr_valid=0 next cycle; first new word is visible the cycle after that.
- Redirect with a simultaneous dequeue: the handshake counts as completed for decode, and the queue is still fully flushed.
- Redirect has no effect while reset=1.
- Reset mid-operation discards queue contents and the halted state in one cycle.

Optional Feature:
- Macro FETCH_BRANCH_PREDECODE_EN.
- Defined:
  - a captured word with rom_data[31:26]==6'b000101 (B imm26) sets next pc <= pc + sext(imm26), truncated to ADDR_W, instead of pc+1;
  - the B word itself is still enqueued;
  - redirect and halt take priority.
- Undefined: B is treated as an ordinary word; pc+1 always, and execute redirects.

Decomposition:
- Shared package legv8_pkg holds:
  - ADDR_W, INSTR_W=32;
  - HALT_WORD;
  - opcode constants (OP_B=6'b000101, OP_BCOND=8'b01010100, OP_BR=11'b11010110000);
  - struct fetch_entry_t {instr, pc}.
- One sub-module: fetch_queue, a 2-entry FIFO of fetch_entry_t with push/pop/flush and count. The PC logic stays in instr_fetch.

Test Plan:
- Reset then instr_ready=1 continuously -> rom_address 0,1,2,... one per cycle; the cycle after the first fetch edge, instr=32'h91002841 with instr_pc=0, followed by 32'hF8001061 with instr_pc=1.
- instr_ready=0 from reset -> queue holds pc 0 and 1, rom_address stays 2, instr_valid=1 stable. Release ready -> instr_pc sequence 0,1,2,3 with no gap or duplicate.
- Queue full, redirect_valid=1, redirect_pc=16'h0004 -> next cycle instr_valid=0, rom_address=4; following cycle instr=32'h910003E7, instr_pc=4.
- Run sequentially to address 16'h000B (rom_data=32'hD60003E0) with the macro undefined -> halt word delivered with instr_pc=11, halted=1, rom_address frozen at 16'h000C, no more instr_valid after the drain. A redirect to 0 -> halted=0 and fetch resumes.
- Macro defined, fetch 16'h000A (32'h17FFFFFA, B -6) -> next rom_address=16'h0004, not 16'h000B.
- Reset asserted with a full queue and halted=1 -> next cycle instr_valid=0, halted=0, rom_address=RESET_PC.
